// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM/WB input bundle, decode read ports and pending-writeback outputs
interface writeback_stage_if #(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 32
);
  logic               in_valid;
  logic [DATA_W-1:0]  final_data;
  logic [7:0]         signals;
  logic [4:0]         dest_reg;
  logic               stall;
  logic               flush;
  logic [4:0]         rs_addr;
  logic [4:0]         rt_addr;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic               wb_valid;
  logic               wb_write;
  logic [4:0]         wb_reg;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_mem_to_reg;
  logic [COUNT_W-1:0] retired_count;

  modport master (
    output in_valid, final_data, signals, dest_reg, stall, flush, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_valid, wb_write, wb_reg, wb_data, wb_mem_to_reg, retired_count
  );

  modport slave (
    input  in_valid, final_data, signals, dest_reg, stall, flush, rs_addr, rt_addr,
    output rs_data, rt_data, wb_valid, wb_write, wb_reg, wb_data, wb_mem_to_reg, retired_count
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, 32x32 register file with bypassed reads, retire counter
module writeback_stage #(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  writeback_stage_if.slave   bus
);

  logic [DATA_W-1:0]  r_regs [32];
  logic               r_valid;
  logic               r_reg_write;
  logic               r_mem_to_reg;
  logic [4:0]         r_reg;
  logic [DATA_W-1:0]  r_data;
  logic [COUNT_W-1:0] r_count;
  logic               w_write;

  assign w_write = r_valid & r_reg_write & (r_reg != 5'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg        <= 5'd0;
      r_data       <= '0;
      r_count      <= '0;
    end else if (!bus.stall) begin
      // Commit the held entry and capture the next one on the same edge.
      if (r_valid) begin
        if (w_write) begin
          r_regs[r_reg] <= r_data;
        end
        r_count <= r_count + 1'b1;
      end
      r_valid      <= bus.in_valid & ~bus.flush;
      r_reg        <= bus.dest_reg;
      r_data       <= bus.final_data;
      r_reg_write  <= bus.signals[5];
      r_mem_to_reg <= bus.signals[6];
    end
  end

  // A pending write is visible to decode before it lands in the file.
  assign bus.rs_data = (bus.rs_addr == 5'd0) ? '0 :
                       (w_write && bus.rs_addr == r_reg) ? r_data : r_regs[bus.rs_addr];
  assign bus.rt_data = (bus.rt_addr == 5'd0) ? '0 :
                       (w_write && bus.rt_addr == r_reg) ? r_data : r_regs[bus.rt_addr];

  assign bus.wb_valid      = r_valid;
  assign bus.wb_write      = w_write;
  assign bus.wb_reg        = r_reg;
  assign bus.wb_data       = r_data;
  assign bus.wb_mem_to_reg = r_mem_to_reg;
  assign bus.retired_count = r_count;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized self-checking bench for writeback_stage against a behavioural model
module tb_writeback_stage;
  localparam int DATA_W  = 32;
  localparam int COUNT_W = 4;
  localparam int CMOD    = 1 << COUNT_W;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  writeback_stage_if #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) bus ();

  writeback_stage #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Architectural view: register array, one pending entry, retire count.
  logic [31:0] m_rf [32];
  bit          m_v;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int unsigned m_count;

  function automatic bit m_wr();
    return m_v && m_we && (m_reg != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_wr() && a == m_reg) return m_data;
    return m_rf[a];
  endfunction

  task automatic step();
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_v = 0; m_we = 0; m_reg = 5'd0; m_data = 32'd0; m_count = 0;
    end else if (!bus.stall) begin
      if (m_v) begin
        if (m_wr()) m_rf[m_reg] = m_data;
        m_count = (m_count + 1) % CMOD;
      end
      m_v    = bus.in_valid && !bus.flush;
      m_we   = bus.signals[5];
      m_reg  = bus.dest_reg;
      m_data = bus.final_data;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] d, input logic [31:0] data, input logic [7:0] sig);
    bus.in_valid   = v;
    bus.dest_reg   = d;
    bus.final_data = data;
    bus.signals    = sig;
  endtask

  task automatic test_reset();
    drive(1, 5'd5, 32'hDEADBEEF, 8'h20);
    step();
    drive(0, 5'd0, 32'd0, 8'h00);
    step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    bus.rs_addr = 5'd5;
    #1;
    checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%0b exp=0", bus.wb_valid); end
    checks++;
    if (bus.wb_write !== 1'b0 || bus.wb_reg !== 5'd0 || bus.wb_data !== 32'd0) begin
      errors++; $display("FAIL reset_wb_fields got=%0b/%0d/%h exp=0/0/0", bus.wb_write, bus.wb_reg, bus.wb_data);
    end
    checks++;
    if (bus.rs_data !== 32'd0) begin errors++; $display("FAIL reset_r5 got=%h exp=0", bus.rs_data); end
    checks++;
    if (bus.retired_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.retired_count); end
  endtask

  task automatic test_basic();
    int unsigned c0;
    c0 = m_count;
    drive(1, 5'd7, 32'h12345678, 8'h20);
    step();
    drive(0, 5'd0, 32'd0, 8'h00);
    bus.rs_addr = 5'd7;
    #1;
    checks++;
    if (bus.wb_write !== 1'b1) begin errors++; $display("FAIL basic_wb_write got=%0b exp=1", bus.wb_write); end
    checks++;
    if (bus.rs_data !== 32'h12345678) begin errors++; $display("FAIL basic_bypass got=%h exp=12345678", bus.rs_data); end
    step();
    checks++;
    if (bus.rs_data !== 32'h12345678) begin errors++; $display("FAIL basic_file got=%h exp=12345678", bus.rs_data); end
    checks++;
    if (bus.retired_count !== COUNT_W'((c0 + 1) % CMOD)) begin
      errors++; $display("FAIL basic_count got=%0d exp=%0d", bus.retired_count, (c0 + 1) % CMOD);
    end
  endtask

  task automatic test_stall();
    int unsigned c0;
    drive(1, 5'd3, 32'hA5A5A5A5, 8'h20);
    step();
    c0 = m_count;
    bus.stall   = 1'b1;
    bus.rs_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'($urandom_range(1, 31)), $urandom, 8'($urandom));
      step();
      checks++;
      if (bus.wb_reg !== 5'd3 || bus.wb_data !== 32'hA5A5A5A5 || bus.wb_write !== 1'b1) begin
        errors++; $display("FAIL stall_hold got=%0d/%h/%0b exp=3/a5a5a5a5/1", bus.wb_reg, bus.wb_data, bus.wb_write);
      end
      checks++;
      if (bus.rs_data !== 32'hA5A5A5A5 || bus.retired_count !== COUNT_W'(c0)) begin
        errors++; $display("FAIL stall_bypass_count got=%h/%0d exp=a5a5a5a5/%0d", bus.rs_data, bus.retired_count, c0);
      end
    end
    bus.stall = 1'b0;
    drive(0, 5'd0, 32'd0, 8'h00);
    step();
    checks++;
    if (bus.retired_count !== COUNT_W'((c0 + 1) % CMOD) || bus.rs_data !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL stall_release got=%0d/%h exp=%0d/a5a5a5a5", bus.retired_count, bus.rs_data, (c0 + 1) % CMOD);
    end
    step();
    checks++;
    if (bus.retired_count !== COUNT_W'((c0 + 1) % CMOD)) begin
      errors++; $display("FAIL stall_single_commit got=%0d exp=%0d", bus.retired_count, (c0 + 1) % CMOD);
    end
  endtask

  task automatic test_flush();
    int unsigned c0;
    c0 = m_count;
    drive(1, 5'd9, 32'h1, 8'h20);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(0, 5'd0, 32'd0, 8'h00);
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_write !== 1'b0) begin
      errors++; $display("FAIL flush_valid got=%0b/%0b exp=0/0", bus.wb_valid, bus.wb_write);
    end
    step();
    bus.rs_addr = 5'd9;
    bus.rt_addr = 5'd10;
    #1;
    checks++;
    if (bus.rs_data !== 32'd0 || bus.retired_count !== COUNT_W'(c0)) begin
      errors++; $display("FAIL flush_noeffect got=%h/%0d exp=0/%0d", bus.rs_data, bus.retired_count, c0);
    end
    drive(1, 5'd10, 32'hCAFEF00D, 8'h08);
    step();
    drive(0, 5'd0, 32'd0, 8'h00);
    step();
    checks++;
    if (bus.retired_count !== COUNT_W'((c0 + 1) % CMOD) || bus.rt_data !== 32'd0) begin
      errors++; $display("FAIL store_retire got=%0d/%h exp=%0d/0", bus.retired_count, bus.rt_data, (c0 + 1) % CMOD);
    end
  endtask

  task automatic test_r0_dual();
    int unsigned c0;
    c0 = m_count;
    drive(1, 5'd0, 32'hFFFFFFFF, 8'h20);
    bus.rs_addr = 5'd0;
    step();
    checks++;
    if (bus.wb_write !== 1'b0 || bus.rs_data !== 32'd0) begin
      errors++; $display("FAIL r0_write got=%0b/%h exp=0/0", bus.wb_write, bus.rs_data);
    end
    drive(1, 5'd4, 32'h55, 8'h20);
    bus.rs_addr = 5'd4;
    bus.rt_addr = 5'd4;
    step();
    drive(0, 5'd0, 32'd0, 8'h00);
    checks++;
    if (bus.rs_data !== 32'h55 || bus.rt_data !== 32'h55) begin
      errors++; $display("FAIL dual_bypass got=%h/%h exp=55/55", bus.rs_data, bus.rt_data);
    end
    checks++;
    if (bus.retired_count !== COUNT_W'((c0 + 1) % CMOD)) begin
      errors++; $display("FAIL r0_count got=%0d exp=%0d", bus.retired_count, (c0 + 1) % CMOD);
    end
    step();
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 5'($urandom_range(0, 31)), $urandom, 8'($urandom));
      step();
    end
    drive(0, 5'd0, 32'd0, 8'h00);
    step();
    checks++;
    if (bus.retired_count !== COUNT_W'(1)) begin
      errors++; $display("FAIL wrap_count got=%0d exp=1", bus.retired_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom, 8'($urandom));
      bus.stall   = ($urandom_range(0, 4) == 0);
      bus.flush   = ($urandom_range(0, 5) == 0);
      bus.rs_addr = ($urandom_range(0, 2) == 0) ? m_reg : 5'($urandom);
      bus.rt_addr = 5'($urandom);
      reset       = ($urandom_range(0, 60) != 0);
      #1;
      checks++;
      if (bus.rs_data !== m_read(bus.rs_addr) || bus.rt_data !== m_read(bus.rt_addr)) begin
        errors++; $display("FAIL rand_read n=%0d got=%h/%h exp=%h/%h", n, bus.rs_data, bus.rt_data,
                           m_read(bus.rs_addr), m_read(bus.rt_addr));
      end
      checks++;
      if (bus.wb_valid !== m_v || bus.wb_write !== m_wr() || bus.wb_reg !== m_reg || bus.wb_data !== m_data) begin
        errors++; $display("FAIL rand_wb n=%0d got=%0b/%0b/%0d/%h exp=%0b/%0b/%0d/%h", n, bus.wb_valid, bus.wb_write,
                           bus.wb_reg, bus.wb_data, m_v, m_wr(), m_reg, m_data);
      end
      checks++;
      if (bus.retired_count !== COUNT_W'(m_count)) begin
        errors++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, bus.retired_count, m_count);
      end
      step();
    end
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive(0, 5'd0, 32'd0, 8'h00);
    bus.stall   = 1'b0;
    bus.flush   = 1'b0;
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    step();
    step();
    reset = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_r0_dual();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the five-stage MIPS core; consumes `final_data` and the 8-bit `signals` bundle produced by the memory stage.
- Contains the MEM/WB pipeline register and the 32x32 architectural register file, with commit, stall and flush control.
- Exposes two combinational read ports with write-through bypass for decode.
- Exposes the pending writeback for forwarding and keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, register/data width.
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  memory stage holds a valid instruction.
- final_data  input  DATA_W  result from the memory stage (ALU result or loaded word).
- signals  input  8  control bundle; bit5 = reg_write, bit6 = MemToReg; other bits are ignored here.
- dest_reg  input  5  destination register number.
- stall  input  1  hold the MEM/WB register; no commit this cycle.
- flush  input  1  kill the instruction being captured.
- rs_addr  input  5  read port A address.
- rt_addr  input  5  read port B address.
- rs_data  output  DATA_W  read port A data (combinational).
- rt_data  output  DATA_W  read port B data (combinational).
- wb_valid  output  1  MEM/WB register holds a valid instruction.
- wb_write  output  1  pending register write: wb_valid & reg_write & (wb_reg != 0).
- wb_reg  output  5  pending destination register.
- wb_data  output  DATA_W  pending write data.
- retired_count  output  COUNT_W  number of committed valid instructions.

Behaviour:
- Reset (reset = 0 at a rising edge):
  - wb_valid, wb_reg, wb_data, the latched reg_write bit and retired_count go to 0.
  - All 32 registers are cleared to 0.
  - Reset overrides stall, flush and commit.
  - Reset mid-operation discards any pending write; the write is not performed.
- Commit happens at the rising edge when reset = 1, stall = 0 and wb_valid = 1:
  - If wb_write = 1, regfile[wb_reg] <= wb_data.
  - retired_count increments by 1, wrapping modulo 2^COUNT_W with no saturation.
  - A valid instruction with reg_write = 0 (e.g. SW, branch) still increments the counter and writes nothing.
- Capture happens at the same edge, when reset = 1 and stall = 0:
  - wb_valid <= in_valid & ~flush.
  - wb_reg <= dest_reg.
  - wb_data <= final_data.
  - The reg_write bit is latched from signals[5].
  - Data fields are captured even when the instruction is invalid; wb_write masks them.
- Latency: an instruction presented at edge N is captured at edge N and committed at edge N+1, provided there is no stall.
- Stall = 1:
  - The MEM/WB register, register file and counter all hold.
  - The pending write stays visible on wb_* and through the bypass.
  - The write happens exactly once, at the first non-stalled edge.
- Stall and flush together: stall wins. The captured entry holds, and flush has no effect that cycle; upstream must reassert flush.
- Register 0:
  - Reads of address 0 always return 0.
  - Writes to register 0 are suppressed (wb_write = 0).
  - An instruction targeting register 0 still counts as retired.
- Read ports are purely combinational:
  - If rX_addr == wb_reg and wb_write = 1, return wb_data (write-through bypass).
  - Otherwise return regfile[rX_addr].
  - Both ports can bypass simultaneously.
- MemToReg (signals[6]) is latched only for observability. The data mux lives upstream, so final_data is already selected.

Test Plan:
- Reset: hold reset = 0 for 2 clocks after writing r5 = 0xDEADBEEF -> all outputs 0, rs_addr = 5 reads 0, retired_count = 0.
- Basic writeback: in_valid = 1, dest_reg = 7, final_data = 0x12345678, signals = 0x20 -> next cycle wb_write = 1 and rs_addr = 7 reads 0x12345678 via bypass; after the commit edge it reads the same from the file; retired_count = 1.
- Stall hold: capture write r3 = 0xA5A5A5A5, then assert stall for 3 cycles while changing inputs -> wb_* unchanged, r3 bypass visible, retired_count unchanged; on release one commit occurs and the count rises by exactly 1.
- Flush and invalid: flush = 1 with r9 = 0x1 -> wb_valid = 0, r9 stays 0, count unchanged; a separate in_valid = 1, signals = 0x08 (SW) -> count +1, no register written.
- r0 and dual bypass: write r0 = 0xFFFFFFFF -> r0 reads 0 and wb_write = 0, count +1; then write r4 = 0x55 with rs_addr = rt_addr = 4 -> both ports return 0x55 before commit.
- Wrap: with COUNT_W = 4, commit 17 valid instructions -> retired_count = 1.
